move_register_fifo: RTL and testbench

- Registered move-entry stage for the N-cell tic-tac-toe board, in "vanishing piece" mode.
- Accepts one-cycle keypad move strobes and validates them against the current board.
- Places the current player's mark, toggles the turn, and keeps a per-player age queue. Once a player exceeds MAX_PIECES, their oldest mark is removed in the same cycle as the new placement.
- Sits between the keypad debouncer and the win-detect/display logic; it owns the authoritative board state.

---
 rtl/move_register_fifo.sv | 173 +++++++++++++++++
 tb/tb_move_register_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/move_register_fifo.sv
// Registered move-entry stage for vanishing-piece tic-tac-toe.
// Owns the board, turn bit and per-player age queues.
module move_register_fifo #(
  parameter int CELLS      = 9,
  parameter int IDX_W      = 4,
  parameter int MAX_PIECES = 3,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 freeze,
  input  logic                 key_valid,
  input  logic [IDX_W-1:0]     key_idx,
  output logic [2*CELLS-1:0]   board,
  output logic                 whos_turn,
  output logic                 move_ok,
  output logic                 move_err,
  output logic                 removed_valid,
  output logic [IDX_W-1:0]     removed_idx,
  output logic [CNT_W-1:0]     count_x,
  output logic [CNT_W-1:0]     count_o
);

  localparam int QD = (MAX_PIECES > 0) ? MAX_PIECES : 1;
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;

  logic [1:0]       cell_q [CELLS];
  logic [1:0]       cell_d [CELLS];
  logic             turn_q, turn_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             rv_q, rv_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [IDX_W-1:0] fifo_q [2][QD];
  logic [IDX_W-1:0] fifo_d [2][QD];
  logic [PW-1:0]    head_q [2];
  logic [PW-1:0]    head_d [2];
  logic [PW-1:0]    tail_q [2];
  logic [PW-1:0]    tail_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic             in_range;
  logic             occupied;
  logic             mover;
  logic [1:0]       mark;
  logic             full;
  logic [IDX_W-1:0] oldest;
  logic             do_clear;
  logic             do_rej;
  logic             do_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_range = {1'b0, key_idx} < (IDX_W + 1)'(CELLS);
    occupied = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (key_idx == IDX_W'(i) && cell_q[i] != 2'b00)
        occupied = 1'b1;
    end
    mover  = turn_q;
    mark   = turn_q ? 2'b01 : 2'b10;
    full   = (MAX_PIECES > 0) &&
             (cnt_q[mover] == CNT_W'(MAX_PIECES));
    oldest = fifo_q[mover][head_q[mover]];
    do_clear = clear;
    do_rej = !clear && key_valid &&
             (freeze || !in_range || occupied);
    do_acc = !clear && key_valid &&
             !freeze && in_range && !occupied;
  end

  always_comb begin
    cell_d = cell_q;
    turn_d = turn_q;
    ok_d   = 1'b0;
    err_d  = 1'b0;
    rv_d   = 1'b0;
    ridx_d = ridx_q;
    fifo_d = fifo_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      do_clear: begin
        for (int i = 0; i < CELLS; i++) cell_d[i] = 2'b00;
        turn_d = 1'b0;
        ridx_d = '0;
        for (int p = 0; p < 2; p++) begin
          head_d[p] = '0;
          tail_d[p] = '0;
          cnt_d[p]  = '0;
        end
      end
      do_rej: begin
        err_d = 1'b1;
      end
      do_acc: begin
        ok_d   = 1'b1;
        turn_d = ~turn_q;
        // the vanished cell is occupied, so it never equals key_idx
        for (int i = 0; i < CELLS; i++) begin
          if (full && oldest == IDX_W'(i))
            cell_d[i] = 2'b00;
          if (key_idx == IDX_W'(i))
            cell_d[i] = mark;
        end
        if (MAX_PIECES > 0) begin
          fifo_d[mover][tail_q[mover]] = key_idx;
          tail_d[mover] = ptr_inc(tail_q[mover]);
          if (full) begin
            head_d[mover] = ptr_inc(head_q[mover]);
            rv_d   = 1'b1;
            ridx_d = oldest;
          end else begin
            cnt_d[mover] = cnt_q[mover] + 1'b1;
          end
        end else if (cnt_q[mover] < CNT_W'(CELLS)) begin
          cnt_d[mover] = cnt_q[mover] + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CELLS; i++) cell_q[i] <= 2'b00;
      turn_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      rv_q   <= 1'b0;
      ridx_q <= '0;
      for (int p = 0; p < 2; p++) begin
        head_q[p] <= '0;
        tail_q[p] <= '0;
        cnt_q[p]  <= '0;
        for (int j = 0; j < QD; j++) fifo_q[p][j] <= '0;
      end
    end else begin
      cell_q <= cell_d;
      turn_q <= turn_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      rv_q   <= rv_d;
      ridx_q <= ridx_d;
      fifo_q <= fifo_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    board = '0;
    for (int i = 0; i < CELLS; i++)
      board[2*i +: 2] = cell_q[i];
  end

  assign whos_turn     = turn_q;
  assign move_ok       = ok_q;
  assign move_err      = err_q;
  assign removed_valid = rv_q;
  assign removed_idx   = ridx_q;
  assign count_x       = cnt_q[0];
  assign count_o       = cnt_q[1];

endmodule

// File: tb/tb_move_register_fifo.sv
// Random + directed bench for move_register_fifo.
// Reference model: board array plus two SV queues for piece age.
module tb_move_register_fifo;

  localparam int CELLS = 9;
  localparam int IDX_W = 4;
  localparam int MAXP  = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             freeze = 1'b0;
  logic             key_valid = 1'b0;
  logic [IDX_W-1:0] key_idx = '0;
  logic [2*CELLS-1:0] board;
  logic             whos_turn;
  logic             move_ok;
  logic             move_err;
  logic             removed_valid;
  logic [IDX_W-1:0] removed_idx;
  logic [CNT_W-1:0] count_x;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int failures = 0;

  logic [1:0] m_cell [CELLS];
  bit         m_turn;
  int         qx[$];
  int         qo[$];
  bit         e_ok, e_err, e_rv;
  int         e_ridx;

  move_register_fifo #(
    .CELLS(CELLS), .IDX_W(IDX_W),
    .MAX_PIECES(MAXP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .freeze(freeze), .key_valid(key_valid),
    .key_idx(key_idx), .board(board),
    .whos_turn(whos_turn), .move_ok(move_ok),
    .move_err(move_err),
    .removed_valid(removed_valid),
    .removed_idx(removed_idx),
    .count_x(count_x), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CELLS; i++) m_cell[i] = 2'b00;
    m_turn = 1'b0;
    qx.delete();
    qo.delete();
    e_ok = 0; e_err = 0; e_rv = 0; e_ridx = 0;
  endtask

  task automatic model_step(input bit c, input bit f,
                            input bit kv, input int idx);
    int r;
    bit bad;
    e_ok = 0; e_err = 0; e_rv = 0;
    if (c) begin
      model_reset();
    end else if (kv) begin
      bad = f || idx >= CELLS;
      if (!bad) bad = m_cell[idx] != 2'b00;
      if (bad) begin
        e_err = 1;
      end else begin
        if (!m_turn) begin
          if (qx.size() == MAXP) begin
            r = qx.pop_front();
            m_cell[r] = 2'b00;
            e_rv = 1; e_ridx = r;
          end
          qx.push_back(idx);
          m_cell[idx] = 2'b10;
        end else begin
          if (qo.size() == MAXP) begin
            r = qo.pop_front();
            m_cell[r] = 2'b00;
            e_rv = 1; e_ridx = r;
          end
          qo.push_back(idx);
          m_cell[idx] = 2'b01;
        end
        m_turn = !m_turn;
        e_ok = 1;
      end
    end
  endtask

  task automatic compare();
    logic [2*CELLS-1:0] eb;
    eb = '0;
    for (int i = 0; i < CELLS; i++) eb[2*i +: 2] = m_cell[i];
    chk("board", 32'(board), 32'(eb));
    chk("whos_turn", 32'(whos_turn), 32'(m_turn));
    chk("move_ok", 32'(move_ok), 32'(e_ok));
    chk("move_err", 32'(move_err), 32'(e_err));
    chk("removed_valid", 32'(removed_valid), 32'(e_rv));
    chk("removed_idx", 32'(removed_idx), 32'(e_ridx));
    chk("count_x", 32'(count_x), 32'(qx.size()));
    chk("count_o", 32'(count_o), 32'(qo.size()));
  endtask

  task automatic step(input bit c, input bit f,
                      input bit kv, input int idx);
    clear = c; freeze = f; key_valid = kv;
    key_idx = IDX_W'(idx);
    model_step(c, f, kv, idx);
    @(posedge clk);
    #1;
    compare();
    clear = 0; freeze = 0; key_valid = 0;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare();
    chk("rst_async_board", 32'(board), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int first_empty();
    for (int i = 0; i < CELLS; i++)
      if (m_cell[i] == 2'b00) return i;
    return 0;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    compare();
    chk("lit_rst_board", 32'(board), 32'd0);
    chk("lit_rst_pulses",
        32'({move_ok, move_err, removed_valid}), 32'd0);

    step(0, 0, 1, 0);
    step(0, 0, 1, 4);
    step(0, 0, 1, 8);
    chk("lit_048_board", 32'(board), 32'd131330);
    chk("lit_048_turn", 32'(whos_turn), 32'd1);
    chk("lit_048_cx", 32'(count_x), 32'd2);
    chk("lit_048_co", 32'(count_o), 32'd1);

    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 3);
    step(0, 0, 1, 1);
    step(0, 0, 1, 4);
    step(0, 0, 1, 2);
    step(0, 0, 1, 5);
    step(0, 0, 1, 6);
    chk("lit_van_rv", 32'(removed_valid), 32'd1);
    chk("lit_van_ridx", 32'(removed_idx), 32'd0);
    chk("lit_van_cx", 32'(count_x), 32'd3);
    chk("lit_van_c0", 32'(board[1:0]), 32'd0);
    chk("lit_van_c6", 32'(board[13:12]), 32'd2);
    step(0, 0, 1, 7);
    chk("lit_van_o_ridx", 32'(removed_idx), 32'd3);

    step(0, 0, 1, 9);
    chk("lit_idx9_err", 32'(move_err), 32'd1);
    step(0, 0, 1, 4);
    chk("lit_occ_err", 32'(move_err), 32'd1);
    chk("lit_occ_turn", 32'(whos_turn), 32'd0);
    step(0, 1, 1, 0);
    chk("lit_frz_err", 32'(move_err), 32'd1);
    step(0, 0, 1, 4);
    step(1, 0, 1, 0);
    chk("lit_clr_board", 32'(board), 32'd0);
    chk("lit_clr_ok", 32'(move_ok), 32'd0);
    chk("lit_clr_turn", 32'(whos_turn), 32'd0);

    for (int k = 0; k < 14; k++) begin
      step(0, 0, 1, first_empty());
      if (k == 6) chk("lit_wrap_ridx", 32'(removed_idx), 32'd0);
      if (k == 7) chk("lit_wrap_ridx2", 32'(removed_idx), 32'd1);
    end
    step(0, 0, 1, first_empty());
    async_reset();

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 10)));
      if ($urandom_range(0, 249) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
